pipeline_controller: RTL and testbench
======================================

// Module: pipeline_controller
// PURPOSE
//  Central sequencer for the 5-stage pipeline (fetch, decode, execute, memory, writeback).
//  Turns stage handshakes into pipeline-register write enables and bubble/flush controls:
//  decode stalls, taken jumps, multi-cycle memory accesses, ebreak halt/resume.
//  Sits beside the stages in cpu top-level; owns no datapath, only control.
// PARAMETERS
//  DRAIN_CYCLES  2    cycles to let older instrs retire after ebreak before HALT (>=1)
//  MEM_TIMEOUT   255  max consecutive MEM_WAIT cycles before fault halt (>=1)
//  CNT_W         32   width of performance counters
// PORTS
//  clk             in   1      clock
//  rst             in   1      synchronous reset, active-high
//  decode_ready    in   1      decode can accept (0 = hazard stall)
//  mem_ready       in   1      memory stage done with current access
//  jump_taken      in   1      execute resolved a taken jump/branch (valid instr)
//  ebreak_seen     in   1      valid ebreak in execute
//  resume          in   1      leave HALT (debug/testbench)
//  if_id_we        out  1      IF/ID register load; also PC advance
//  id_ex_we        out  1      ID/EX register load
//  ex_mem_we       out  1      EX/MEM register load
//  mem_wb_we       out  1      MEM/WB register load
//  flush_if_id     out  1      load bubble (valid=0) into IF/ID
//  flush_id_ex     out  1      load bubble into ID/EX
//  halted          out  1      in HALT
//  fault           out  1      sticky: HALT entered via memory timeout
//  stall_count     out  CNT_W  cycles with if_id_we=0 while not HALT
//  flush_count     out  CNT_W  taken-jump flush events
// BEHAVIOUR
//  States (ctrl_state_t): RUN, MEM_WAIT, DRAIN, HALT. Reset -> RUN, counters 0, fault 0.
//  While rst=1: all *_we=0, flush_*=1, halted=0. Outputs combinational from state+inputs.
//  Event priority per cycle: mem_ready=0 > ebreak_seen > jump_taken > decode_ready=0.
//  RUN: default all *_we=1, flush_*=0.
//   mem_ready=0 -> all *_we=0 this cycle, go MEM_WAIT, timeout cnt=1.
//   ebreak_seen -> if_id_we=0, flush_if_id=1, flush_id_ex=1, go DRAIN, drain cnt=0.
//   jump_taken  -> flush_if_id=1, flush_id_ex=1, all *_we=1 (PC loads target); flush_count+1.
//   decode_ready=0 -> if_id_we=0 (hold PC, IF/ID), flush_id_ex=1, rest advance.
//  MEM_WAIT: all *_we=0, flush_*=0; timeout cnt+1 per cycle.
//   mem_ready=1 -> outputs as RUN for this cycle (same rules), next RUN.
//   cnt reaches MEM_TIMEOUT with mem_ready=0 -> HALT, fault=1.
//  DRAIN: if_id_we=0, flush_id_ex=1, ex_mem_we=mem_wb_we=1; mem_ready=0 freezes all
//   and pauses drain cnt (no timeout in DRAIN... timeout still counts, same fault rule).
//   jump_taken ignored. cnt==DRAIN_CYCLES-1 -> HALT.
//  HALT: all *_we=0, flush_*=0, halted=1. resume=1 -> RUN next cycle; fault cleared on resume.
//  Counters wrap modulo 2^CNT_W. Reset mid-state returns to RUN same edge.
// CONFIGURATION
//  PIPELINE_PERF_CNT_EN defined: stall_count/flush_count implemented as above.
//  Not defined: both outputs tied 0, no counter flops synthesised.
// STRUCTURE
//  cpu_types package: ctrl_state_t enum {RUN,MEM_WAIT,DRAIN,HALT}; pipe_ctrl_t struct
//  (four we bits + two flush bits) used by top-level wiring.
//  One sub-module: ctrl_counter (clear, enable, WIDTH param, wrap) reused for drain,
//  timeout and perf counters.
// TESTING
//  1 reset then idle inputs ready -> all *_we=1, flush_*=0, halted=0 on cycle 1.
//  2 decode_ready=0 for 3 cycles -> if_id_we=0, flush_id_ex=1 for exactly 3 cycles;
//    stall_count=3 (with PIPELINE_PERF_CNT_EN).
//  3 jump_taken pulse with decode_ready=0 same cycle -> flush_if_id=flush_id_ex=1,
//    if_id_we=1; flush_count=1.
//  4 mem_ready=0 for 4 cycles then 1 -> all *_we=0 4 cycles, RUN outputs on release;
//    MEM_TIMEOUT=3 variant -> halted=1, fault=1 after 3rd wait cycle.
//  5 ebreak_seen, DRAIN_CYCLES=2 -> 2 drain cycles (if_id_we=0, ex_mem_we=1), then
//    halted=1; resume pulse -> RUN next cycle, fault=0.
//  6 rst asserted during DRAIN -> next cycle RUN, counters 0, halted=0.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// Shared types for the pipeline sequencer: controller state encoding and the
// bundle of pipeline-register write enables / bubble controls.
package pipeline_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALT     = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic flush_if_id;
        logic flush_id_ex;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_IDLE    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_ADVANCE = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_RESET   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Handshake and control bundle between the pipeline stages and the sequencer.
// master: the controller side; slave: the stage/datapath side.
interface pipeline_controller_if #(
    parameter int CNT_W = 32
);
    logic             decode_ready;
    logic             mem_ready;
    logic             jump_taken;
    logic             ebreak_seen;
    logic             resume;
    logic             if_id_we;
    logic             id_ex_we;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        input  decode_ready, mem_ready, jump_taken, ebreak_seen, resume,
        output if_id_we, id_ex_we, ex_mem_we, mem_wb_we, flush_if_id, flush_id_ex,
        output halted, fault, stall_count, flush_count
    );

    modport slave (
        output decode_ready, mem_ready, jump_taken, ebreak_seen, resume,
        input  if_id_we, id_ex_we, ex_mem_we, mem_wb_we, flush_if_id, flush_id_ex,
        input  halted, fault, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_controller_counter.sv
// Generic wrapping up-counter with synchronous clear; used for the drain,
// memory-timeout and performance counters.
module pipeline_controller_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencer: stage handshakes -> register write enables and bubbles.
// Optional performance counters are built only when PIPELINE_PERF_CNT_EN is defined.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_controller_if.master bus
);
    localparam int DR_W = cnt_width(DRAIN_CYCLES);
    localparam int TO_W = cnt_width(MEM_TIMEOUT);

    ctrl_state_t     state_reg;
    ctrl_state_t     state_next;
    pipe_ctrl_t      ctrl;
    pipe_ctrl_t      ctrl_out;
    logic            fault_reg;
    logic            fault_set;
    logic            jump_evt;
    logic            run_eval;
    logic            timeout_hit;
    logic [DR_W-1:0] drain_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W:0]   to_inc;

    // Timeout counter holds consecutive mem_ready=0 cycles seen so far; the
    // current stalled cycle is the (to_cnt+1)-th.
    assign to_inc      = {1'b0, to_cnt} + (TO_W + 1)'(1);
    assign timeout_hit = (to_inc >= (TO_W + 1)'(MEM_TIMEOUT));

    pipeline_controller_counter #(.WIDTH(TO_W)) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.mem_ready || (state_reg == HALT)),
        .enable (!bus.mem_ready && (state_reg != HALT)),
        .count  (to_cnt)
    );

    pipeline_controller_counter #(.WIDTH(DR_W)) u_drain_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_reg != DRAIN),
        .enable ((state_reg == DRAIN) && bus.mem_ready),
        .count  (drain_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (fault_set) begin
                fault_reg <= 1'b1;
            end else if ((state_reg == HALT) && bus.resume) begin
                fault_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ctrl       = CTRL_IDLE;
        fault_set  = 1'b0;
        jump_evt   = 1'b0;
        run_eval   = 1'b0;

        unique case (state_reg)
            RUN: run_eval = 1'b1;
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    run_eval = 1'b1;
                end else if (timeout_hit) begin
                    state_next = HALT;
                    fault_set  = 1'b1;
                end
            end
            DRAIN: begin
                if (!bus.mem_ready) begin
                    if (timeout_hit) begin
                        state_next = HALT;
                        fault_set  = 1'b1;
                    end
                end else begin
                    ctrl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
                    if (drain_cnt == DR_W'(DRAIN_CYCLES - 1)) begin
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                if (bus.resume) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        // Shared RUN rules, also applied on the cycle a memory wait releases.
        if (run_eval) begin
            ctrl = CTRL_ADVANCE;
            if (!bus.mem_ready) begin
                ctrl       = CTRL_IDLE;
                state_next = timeout_hit ? HALT : MEM_WAIT;
                fault_set  = timeout_hit;
            end else if (bus.ebreak_seen) begin
                ctrl.if_id_we    = 1'b0;
                ctrl.flush_if_id = 1'b1;
                ctrl.flush_id_ex = 1'b1;
                state_next       = DRAIN;
            end else if (bus.jump_taken) begin
                ctrl.flush_if_id = 1'b1;
                ctrl.flush_id_ex = 1'b1;
                jump_evt         = 1'b1;
                state_next       = RUN;
            end else begin
                if (!bus.decode_ready) begin
                    ctrl.if_id_we    = 1'b0;
                    ctrl.flush_id_ex = 1'b1;
                end
                state_next = RUN;
            end
        end
    end

    assign ctrl_out        = rst ? CTRL_RESET : ctrl;
    assign bus.if_id_we    = ctrl_out.if_id_we;
    assign bus.id_ex_we    = ctrl_out.id_ex_we;
    assign bus.ex_mem_we   = ctrl_out.ex_mem_we;
    assign bus.mem_wb_we   = ctrl_out.mem_wb_we;
    assign bus.flush_if_id = ctrl_out.flush_if_id;
    assign bus.flush_id_ex = ctrl_out.flush_id_ex;
    assign bus.halted      = !rst && (state_reg == HALT);
    assign bus.fault       = fault_reg;

`ifdef PIPELINE_PERF_CNT_EN
    logic [1:0]       perf_en;
    logic [CNT_W-1:0] perf_cnt [2];

    assign perf_en[0] = !ctrl.if_id_we && (state_reg != HALT);
    assign perf_en[1] = jump_evt;

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        pipeline_controller_counter #(.WIDTH(CNT_W)) u_perf_cnt (
            .clk    (clk),
            .rst    (rst),
            .clear  (1'b0),
            .enable (perf_en[gi]),
            .count  (perf_cnt[gi])
        );
    end

    assign bus.stall_count = perf_cnt[0];
    assign bus.flush_count = perf_cnt[1];
`else
    logic unused_jump_evt;
    assign unused_jump_evt = jump_evt;
    assign bus.stall_count = '0;
    assign bus.flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller; dut_a uses default parameters,
// dut_b uses MEM_TIMEOUT=3 for the fault-halt scenario.
module tb_pipeline_controller;
    localparam int CNT_W = 32;
`ifdef PIPELINE_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    // {if_id_we, id_ex_we, ex_mem_we, mem_wb_we, flush_if_id, flush_id_ex}
    localparam logic [5:0] C_ADV   = 6'b111100;
    localparam logic [5:0] C_RST   = 6'b000011;
    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_DSTL  = 6'b011101;
    localparam logic [5:0] C_JUMP  = 6'b111111;
    localparam logic [5:0] C_EBRK  = 6'b011111;
    localparam logic [5:0] M_DRAIN = 6'b101111;
    localparam logic [5:0] C_DRAIN = 6'b001101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipeline_controller_if #(.CNT_W(CNT_W)) bus_a ();
    pipeline_controller_if #(.CNT_W(CNT_W)) bus_b ();

    pipeline_controller #(.DRAIN_CYCLES(2), .MEM_TIMEOUT(255), .CNT_W(CNT_W)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    pipeline_controller #(.DRAIN_CYCLES(2), .MEM_TIMEOUT(3), .CNT_W(CNT_W)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    function automatic logic [5:0] ctl_a();
        return {bus_a.if_id_we, bus_a.id_ex_we, bus_a.ex_mem_we, bus_a.mem_wb_we,
                bus_a.flush_if_id, bus_a.flush_id_ex};
    endfunction

    function automatic logic [5:0] ctl_b();
        return {bus_b.if_id_we, bus_b.id_ex_we, bus_b.ex_mem_we, bus_b.mem_wb_we,
                bus_b.flush_if_id, bus_b.flush_id_ex};
    endfunction

    // Apply inputs at the falling edge, then settle before sampling.
    task automatic drive_a(input logic dr, input logic mr, input logic jt,
                           input logic eb, input logic rs);
        @(negedge clk);
        bus_a.decode_ready = dr;
        bus_a.mem_ready    = mr;
        bus_a.jump_taken   = jt;
        bus_a.ebreak_seen  = eb;
        bus_a.resume       = rs;
        #1;
    endtask

    task automatic drive_b(input logic mr, input logic rs);
        @(negedge clk);
        bus_b.decode_ready = 1'b1;
        bus_b.mem_ready    = mr;
        bus_b.jump_taken   = 1'b0;
        bus_b.ebreak_seen  = 1'b0;
        bus_b.resume       = rs;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_b(1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_b(1'b1, 1'b0);
        total++;
        if (ctl_a() !== C_RST) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl_a(), C_RST); end
        else $display("ok reset_ctl %b", ctl_a());
        total++;
        if (bus_a.halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", bus_a.halted); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (ctl_a() !== C_ADV) begin bad++; $display("FAIL run_cycle1_ctl: got %b want %b", ctl_a(), C_ADV); end
        else $display("ok run_cycle1_ctl %b", ctl_a());
        total++;
        if (bus_a.halted !== 1'b0 || bus_a.fault !== 1'b0) begin
            bad++; $display("FAIL run_cycle1_status: got halted=%b fault=%b want 0 0", bus_a.halted, bus_a.fault);
        end
        total++;
        if (bus_a.stall_count !== 0 || bus_a.flush_count !== 0) begin
            bad++; $display("FAIL reset_counters: got %0d %0d want 0 0", bus_a.stall_count, bus_a.flush_count);
        end
    endtask

    task automatic test_decode_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            total++;
            if (ctl_a() !== C_DSTL) begin bad++; $display("FAIL dstall_ctl[%0d]: got %b want %b", i, ctl_a(), C_DSTL); end
            else $display("ok dstall_ctl[%0d] %b", i, ctl_a());
        end
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (ctl_a() !== C_ADV) begin bad++; $display("FAIL dstall_release: got %b want %b", ctl_a(), C_ADV); end
        else $display("ok dstall_release %b", ctl_a());
        total++;
        if (bus_a.stall_count !== CNT_W'(3 * PERF)) begin
            bad++; $display("FAIL stall_count: got %0d want %0d", bus_a.stall_count, 3 * PERF);
        end else $display("ok stall_count %0d", bus_a.stall_count);
    endtask

    task automatic test_jump();
        do_reset();
        drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (ctl_a() !== C_JUMP) begin bad++; $display("FAIL jump_ctl: got %b want %b", ctl_a(), C_JUMP); end
        else $display("ok jump_ctl %b", ctl_a());
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (ctl_a() !== C_ADV) begin bad++; $display("FAIL jump_after: got %b want %b", ctl_a(), C_ADV); end
        total++;
        if (bus_a.flush_count !== CNT_W'(PERF)) begin
            bad++; $display("FAIL flush_count: got %0d want %0d", bus_a.flush_count, PERF);
        end else $display("ok flush_count %0d", bus_a.flush_count);
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            total++;
            if (ctl_a() !== C_IDLE || bus_a.halted !== 1'b0) begin
                bad++; $display("FAIL memwait_ctl[%0d]: got %b halted=%b want %b halted=0", i, ctl_a(), bus_a.halted, C_IDLE);
            end else $display("ok memwait_ctl[%0d] %b", i, ctl_a());
        end
        // Release coincides with a decode stall: RUN rules apply on this cycle.
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (ctl_a() !== C_DSTL) begin bad++; $display("FAIL memwait_release: got %b want %b", ctl_a(), C_DSTL); end
        else $display("ok memwait_release %b", ctl_a());
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (ctl_a() !== C_ADV) begin bad++; $display("FAIL memwait_run: got %b want %b", ctl_a(), C_ADV); end
        total++;
        if (bus_a.stall_count !== CNT_W'(5 * PERF)) begin
            bad++; $display("FAIL memwait_stalls: got %0d want %0d", bus_a.stall_count, 5 * PERF);
        end
    endtask

    task automatic test_mem_timeout();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_b(1'b0, 1'b0);
            total++;
            if (ctl_b() !== C_IDLE || bus_b.halted !== 1'b0) begin
                bad++; $display("FAIL timeout_wait[%0d]: got %b halted=%b want %b halted=0", i, ctl_b(), bus_b.halted, C_IDLE);
            end else $display("ok timeout_wait[%0d] %b", i, ctl_b());
        end
        drive_b(1'b1, 1'b1);
        total++;
        if (bus_b.halted !== 1'b1 || bus_b.fault !== 1'b1 || ctl_b() !== C_IDLE) begin
            bad++; $display("FAIL timeout_halt: got halted=%b fault=%b ctl=%b want 1 1 %b", bus_b.halted, bus_b.fault, ctl_b(), C_IDLE);
        end else $display("ok timeout_halt");
        drive_b(1'b1, 1'b0);
        total++;
        if (bus_b.halted !== 1'b0 || bus_b.fault !== 1'b0 || ctl_b() !== C_ADV) begin
            bad++; $display("FAIL timeout_resume: got halted=%b fault=%b ctl=%b want 0 0 %b", bus_b.halted, bus_b.fault, ctl_b(), C_ADV);
        end else $display("ok timeout_resume");
    endtask

    task automatic test_ebreak();
        do_reset();
        drive_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (ctl_a() !== C_EBRK) begin bad++; $display("FAIL ebreak_ctl: got %b want %b", ctl_a(), C_EBRK); end
        else $display("ok ebreak_ctl %b", ctl_a());
        // jump_taken during DRAIN must not flush IF/ID.
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            total++;
            if ((ctl_a() & M_DRAIN) !== C_DRAIN || bus_a.halted !== 1'b0) begin
                bad++; $display("FAIL drain_ctl[%0d]: got %b halted=%b want %b (mask %b)", i, ctl_a(), bus_a.halted, C_DRAIN, M_DRAIN);
            end else $display("ok drain_ctl[%0d] %b", i, ctl_a());
        end
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus_a.halted !== 1'b1 || ctl_a() !== C_IDLE) begin
            bad++; $display("FAIL ebreak_halt: got halted=%b ctl=%b want 1 %b", bus_a.halted, ctl_a(), C_IDLE);
        end else $display("ok ebreak_halt");
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus_a.halted !== 1'b0 || bus_a.fault !== 1'b0 || ctl_a() !== C_ADV) begin
            bad++; $display("FAIL ebreak_resume: got halted=%b fault=%b ctl=%b want 0 0 %b", bus_a.halted, bus_a.fault, ctl_a(), C_ADV);
        end else $display("ok ebreak_resume");
    endtask

    task automatic test_drain_pause();
        do_reset();
        drive_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (ctl_a() !== C_IDLE || bus_a.halted !== 1'b0) begin
            bad++; $display("FAIL drain_freeze: got %b halted=%b want %b halted=0", ctl_a(), bus_a.halted, C_IDLE);
        end else $display("ok drain_freeze %b", ctl_a());
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if ((ctl_a() & M_DRAIN) !== C_DRAIN || bus_a.halted !== 1'b0) begin
            bad++; $display("FAIL drain_second: got %b halted=%b want %b", ctl_a(), bus_a.halted, C_DRAIN);
        end else $display("ok drain_second %b", ctl_a());
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus_a.halted !== 1'b1 || bus_a.fault !== 1'b0) begin
            bad++; $display("FAIL drain_pause_halt: got halted=%b fault=%b want 1 0", bus_a.halted, bus_a.fault);
        end else $display("ok drain_pause_halt");
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        total++;
        if (ctl_a() !== C_RST || bus_a.halted !== 1'b0) begin
            bad++; $display("FAIL rst_in_drain: got %b halted=%b want %b halted=0", ctl_a(), bus_a.halted, C_RST);
        end else $display("ok rst_in_drain %b", ctl_a());
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (ctl_a() !== C_ADV || bus_a.halted !== 1'b0) begin
            bad++; $display("FAIL rst_drain_run: got %b halted=%b want %b halted=0", ctl_a(), bus_a.halted, C_ADV);
        end else $display("ok rst_drain_run %b", ctl_a());
        total++;
        if (bus_a.stall_count !== 0 || bus_a.flush_count !== 0) begin
            bad++; $display("FAIL rst_drain_counters: got %0d %0d want 0 0", bus_a.stall_count, bus_a.flush_count);
        end
    endtask

    initial begin
        test_reset();
        test_decode_stall();
        test_jump();
        test_mem_wait();
        test_mem_timeout();
        test_ebreak();
        test_drain_pause();
        test_reset_in_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
